multdiv_stall_controller: RTL

- Sequences the multi-cycle multiply/divide unit from the execute (DX) stage of the 5-stage pipeline.
- Detects mul/div in the DX latch, freezes PC/FD/DX while the unit runs, and issues the one-cycle start pulse.
- Waits for ready or timeout, then presents the result or an $rstatus exception write for the instruction as it advances to XM.
- Sits beside the data-hazard detector; its stall is ORed with the hazard stall at the top level.

---
 rtl/multdiv_stall_controller.sv | 136 +++++++++++++
 1 files changed

// File: rtl/multdiv_stall_controller.sv
// Sequences the multi-cycle multiply/divide unit from the DX stage: detects mul/div,
// stalls the front of the pipe, pulses the start, and presents the writeback at DONE.
module multdiv_stall_controller #(
    parameter int MAX_CYCLES  = 40,
    parameter int CNT_W       = 6,
    parameter int RSTATUS_REG = 30,
    parameter int MUL_STATUS  = 4,
    parameter int DIV_STATUS  = 5
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] dx_insn,
    input  logic        dx_valid,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_ready,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic        stall,
    output logic        busy,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        timeout_err
);

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(MAX_CYCLES - 1);
    localparam logic [4:0]       LP_RSTATUS  = 5'(RSTATUS_REG);
    localparam logic [31:0]      LP_MUL_CODE = 32'(MUL_STATUS);
    localparam logic [31:0]      LP_DIV_CODE = 32'(DIV_STATUS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_rd;
    logic             r_is_div;
    logic             r_ctrl_mult;
    logic             r_ctrl_div;
    logic             r_wb_valid;
    logic             r_timeout;
    logic [4:0]       r_wb_rd;
    logic [31:0]      r_wb_data;

    logic [4:0]       w_opcode;
    logic [4:0]       w_aluop;
    logic             w_md_detect;
    logic             w_unused_insn;

    assign w_opcode      = dx_insn[31:27];
    assign w_aluop       = dx_insn[6:2];
    assign w_md_detect   = dx_valid && (w_opcode == 5'b00000) &&
                           ((w_aluop == 5'b00110) || (w_aluop == 5'b00111));
    assign w_unused_insn = ^{dx_insn[21:7], dx_insn[1:0]};

    // Single-cycle strobes default low every edge; only the state that owns them raises them.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rd        <= '0;
            r_is_div    <= 1'b0;
            r_ctrl_mult <= 1'b0;
            r_ctrl_div  <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_timeout   <= 1'b0;
            r_wb_rd     <= '0;
            r_wb_data   <= '0;
        end else begin
            r_ctrl_mult <= 1'b0;
            r_ctrl_div  <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_timeout   <= 1'b0;
            r_wb_rd     <= '0;
            r_wb_data   <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_md_detect) begin
                        r_rd        <= dx_insn[26:22];
                        r_is_div    <= w_aluop[0];
                        r_ctrl_mult <= ~w_aluop[0];
                        r_ctrl_div  <= w_aluop[0];
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    // A ready in the final allowed cycle still wins over the timeout.
                    if (md_ready) begin
                        r_wb_valid <= 1'b1;
                        r_state    <= S_DONE;
                        if (md_exception) begin
                            r_wb_rd   <= LP_RSTATUS;
                            r_wb_data <= r_is_div ? LP_DIV_CODE : LP_MUL_CODE;
                        end else begin
                            r_wb_rd   <= r_rd;
                            r_wb_data <= md_result;
                        end
                    end else if (r_cnt == LP_CNT_LAST) begin
                        r_wb_valid <= 1'b1;
                        r_timeout  <= 1'b1;
                        r_wb_rd    <= LP_RSTATUS;
                        r_wb_data  <= r_is_div ? LP_DIV_CODE : LP_MUL_CODE;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Stall must rise in the detect cycle itself so DX holds, and drop in DONE so it advances.
    assign stall       = reset_n && ((r_state == S_IDLE) ? w_md_detect : (r_state != S_DONE));
    assign busy        = (r_state != S_IDLE);
    assign ctrl_mult   = r_ctrl_mult;
    assign ctrl_div    = r_ctrl_div;
    assign wb_valid    = r_wb_valid;
    assign wb_rd       = r_wb_rd;
    assign wb_data     = r_wb_data;
    assign timeout_err = r_timeout;

endmodule
